// File: rtl/nios2_c_mem_copy_master.sv
// nios2_c_mem_copy_master: Avalon-MM initiator that copies or fills blocks of on-chip memory.
module nios2_c_mem_copy_master #(
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 75000
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   src_addr,
  input  logic [ADDR_W-1:0]   dst_addr,
  input  logic [ADDR_W-1:0]   length,
  input  logic [DATA_W-1:0]   fill_value,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [ADDR_W-1:0]   m_address,
  output logic                m_chipselect,
  output logic                m_write,
  output logic [DATA_W/8-1:0] m_byteenable,
  output logic [DATA_W-1:0]   m_writedata,
  input  logic [DATA_W-1:0]   m_readdata
);
  typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_WR, S_FILL, S_DONE} state_t;
  localparam logic [ADDR_W:0] LIM = (ADDR_W+1)'(MEM_DEPTH);
  state_t              r_state, w_next;
  logic                r_mode, r_error;
  logic [ADDR_W-1:0]   r_src, r_dst, r_len, r_idx;
  logic [DATA_W-1:0]   r_fill, r_cap;
  logic [ADDR_W:0]     w_dst_end, w_src_end;
  logic                w_err, w_last, w_accept, w_rd, w_wr;
  // Range sums are one bit wider so an end beyond the address space cannot wrap past the check.
  assign w_dst_end = {1'b0, dst_addr} + {1'b0, length};
  assign w_src_end = {1'b0, src_addr} + {1'b0, length};
  assign w_err     = (w_dst_end > LIM) || (!mode && (w_src_end > LIM));
  assign w_last    = (r_idx + 1'b1) == r_len;
  assign w_accept  = (r_state == S_IDLE) && start;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = !start ? S_IDLE : (w_err || length == '0) ? S_DONE : mode ? S_FILL : S_RD;
      S_RD:   w_next = S_CAP;
      S_CAP:  w_next = S_WR;
      S_WR:   w_next = w_last ? S_DONE : S_RD;
      S_FILL: w_next = w_last ? S_DONE : S_FILL;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_mode  <= 1'b0;
      r_error <= 1'b0;
      r_src   <= '0;
      r_dst   <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_fill  <= '0;
      r_cap   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mode  <= mode;
        r_error <= w_err;
        r_src   <= src_addr;
        r_dst   <= dst_addr;
        r_len   <= length;
        r_fill  <= fill_value;
        r_idx   <= '0;
      end
      if (r_state == S_CAP) r_cap <= m_readdata;
      if (r_state == S_WR || r_state == S_FILL) r_idx <= r_idx + 1'b1;
    end
  end
  assign w_rd         = r_state == S_RD;
  assign w_wr         = r_state == S_WR || r_state == S_FILL;
  assign busy         = w_rd || w_wr || r_state == S_CAP;
  assign done         = r_state == S_DONE;
  assign error        = r_error;
  assign m_chipselect = w_rd || w_wr;
  assign m_write      = w_wr;
  assign m_byteenable = {(DATA_W/8){m_chipselect}};
  assign m_address    = w_rd ? r_src + r_idx : w_wr ? r_dst + r_idx : '0;
  // Mode selects the write source; the latched mode keeps the fill path quiet during copies.
  assign m_writedata  = (r_state == S_WR) ? r_cap : (r_state == S_FILL && r_mode) ? r_fill : '0;
endmodule
